// File: rtl/acc_alu_core.sv
// Single-issue accumulator ALU with a small scratch memory.
// Each command runs IDLE -> EXEC -> RESP, and the response is held until the consumer takes it.
module acc_alu_core #(
   parameter  int DATA_W    = 8,
   parameter  int MEM_DEPTH = 16,
   localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [3:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [2:0]        rsp_flags,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_RESP
   } state_t;

   typedef enum logic [3:0] {
      OP_ADD   = 4'd0,
      OP_SUB   = 4'd1,
      OP_STORE = 4'd2,
      OP_LOAD  = 4'd3,
      OP_LDI   = 4'd4,
      OP_AND   = 4'd5,
      OP_OR    = 4'd6,
      OP_XOR   = 4'd7,
      OP_NOT   = 4'd8,
      OP_SHL   = 4'd9,
      OP_SHR   = 4'd10,
      OP_ADDM  = 4'd11,
      OP_SUBM  = 4'd12,
      OP_NOP   = 4'd15
   } op_t;

   typedef struct packed {
      logic err;
      logic carry;
      logic zero;
   } flags_t;

   state_t            state;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] imm_q;

   logic [DATA_W-1:0] acc;
   flags_t            flags;
   logic [DATA_W-1:0] mem [MEM_DEPTH];

   logic              exec;
   logic [DATA_W-1:0] mem_rd;
   logic [DATA_W-1:0] opnd;
   logic [DATA_W:0]   sum;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] nxt_acc;
   logic              nxt_carry;
   logic              nxt_err;
   logic              mem_we;

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);
   assign exec      = (state == ST_EXEC);
   assign rsp_data  = acc;
   assign rsp_flags = flags;

   // Memory operands come from the pre-edge contents, so LOAD/ADDM/SUBM never see a same-cycle write.
   assign mem_rd = mem[addr_q];
   assign opnd   = ((op_q == OP_ADDM) || (op_q == OP_SUBM)) ? mem_rd : imm_q;
   assign sum    = {1'b0, acc} + {1'b0, opnd};
   assign diff   = {1'b0, acc} - {1'b0, opnd};

   // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      nxt_acc   = acc;
      nxt_carry = 1'b0;
      nxt_err   = 1'b0;
      mem_we    = 1'b0;
      case (op_q)
         OP_ADD, OP_ADDM: begin
            nxt_acc   = sum[DATA_W-1:0];
            nxt_carry = sum[DATA_W];
         end
         OP_SUB, OP_SUBM: begin
            nxt_acc   = diff[DATA_W-1:0];
            nxt_carry = diff[DATA_W];
         end
         OP_STORE: mem_we  = 1'b1;
         OP_LOAD:  nxt_acc = mem_rd;
         OP_LDI:   nxt_acc = imm_q;
         OP_AND:   nxt_acc = acc & imm_q;
         OP_OR:    nxt_acc = acc | imm_q;
         OP_XOR:   nxt_acc = acc ^ imm_q;
         OP_NOT:   nxt_acc = ~acc;
         OP_SHL: begin
            nxt_acc   = {acc[DATA_W-2:0], 1'b0};
            nxt_carry = acc[DATA_W-1];
         end
         OP_SHR: begin
            nxt_acc   = {1'b0, acc[DATA_W-1:1]};
            nxt_carry = acc[0];
         end
         OP_NOP:   nxt_acc = acc;
         default:  nxt_err = 1'b1;
      endcase
   end

   // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rsp_valid <= 1'b0;
         op_q      <= OP_NOP;
         addr_q    <= '0;
         imm_q     <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q   <= cmd_op;
                  addr_q <= cmd_addr;
                  imm_q  <= cmd_data;
                  state  <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               state     <= ST_RESP;
               rsp_valid <= 1'b1;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  state     <= ST_IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         flags <= '0;
      end else if (exec) begin
         acc   <= nxt_acc;
         flags <= '{err: nxt_err, carry: nxt_carry, zero: (nxt_acc == '0)};
      end
   end

   // NOTE: the scratch memory must read zero after reset, so it is a reset flop array rather than a RAM macro.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (exec && mem_we) begin
         mem[addr_q] <= acc;
      end
   end

endmodule

// File: tb/tb_acc_alu_core.sv
// Self-checking bench for acc_alu_core (DATA_W=8, MEM_DEPTH=16): directed vector table,
// stall and reset-in-EXEC sequences, then random commands against an arithmetic model.
module tb_acc_alu_core;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_op;
   logic [3:0] cmd_addr;
   logic [7:0] cmd_data;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [7:0] rsp_data;
   logic [2:0] rsp_flags;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int m_acc;
   int m_mem [16];

   typedef struct {
      logic [3:0] op;
      logic [3:0] addr;
      logic [7:0] data;
      logic [7:0] exp_d;
      logic [2:0] exp_f;
   } vec_t;

   vec_t vecs [$];

   acc_alu_core #(.DATA_W(8), .MEM_DEPTH(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_addr  (cmd_addr),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_flags (rsp_flags),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got no summary expected summary");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issues one command starting just after a falling edge, checks latency, optional stall
   // (rsp_ready low with a competing command that must be ignored), and the return to IDLE.
   task automatic do_cmd(input logic [3:0] op, input logic [3:0] addr, input logic [7:0] d,
                         input int stall, input logic [7:0] exp_d, input logic [2:0] exp_f,
                         input string name);
      int n;
      n = 0;
      while (!cmd_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check({name, "_ready"}, cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_data  = d;
      rsp_ready = (stall == 0);
      @(negedge clk);  // acceptance edge N is behind us: EXEC
      cmd_valid = 1'b0;
      cmd_op    = 4'($urandom);
      cmd_addr  = 4'($urandom);
      cmd_data  = 8'($urandom);
      check({name, "_exec_busy"}, busy, 1);
      check({name, "_exec_novalid"}, rsp_valid, 0);
      @(negedge clk);  // edge N+1 done: first edge to sample rsp_valid high is N+2
      check({name, "_valid"}, rsp_valid, 1);
      check({name, "_data"}, rsp_data, exp_d);
      check({name, "_flags"}, rsp_flags, exp_f);
      for (int k = 0; k < stall; k++) begin
         cmd_valid = 1'b1;
         cmd_op    = 4'd4;
         cmd_data  = 8'h33;
         @(negedge clk);
         check({name, "_stall_valid"}, rsp_valid, 1);
         check({name, "_stall_data"}, rsp_data, exp_d);
         check({name, "_stall_flags"}, rsp_flags, exp_f);
         check({name, "_stall_notready"}, cmd_ready, 0);
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      @(negedge clk);
      check({name, "_taken"}, rsp_valid, 0);
      check({name, "_idle"}, cmd_ready, 1);
   endtask

   function automatic void model(input int op, input int addr, input int imm,
                                 output int exp_d, output int exp_f);
      int a, m, r, c, e;
      a = m_acc;
      m = m_mem[addr];
      c = 0;
      e = 0;
      case (op)
         0:  begin r = a + imm; c = (r > 255) ? 1 : 0; a = r % 256; end
         1:  begin c = (a < imm) ? 1 : 0; a = (a - imm + 256) % 256; end
         2:  m_mem[addr] = a;
         3:  a = m;
         4:  a = imm;
         5:  a = a & imm;
         6:  a = a | imm;
         7:  a = a ^ imm;
         8:  a = 255 - a;
         9:  begin c = (a >= 128) ? 1 : 0; a = (a * 2) % 256; end
         10: begin c = a % 2; a = a / 2; end
         11: begin r = a + m; c = (r > 255) ? 1 : 0; a = r % 256; end
         12: begin c = (a < m) ? 1 : 0; a = (a - m + 256) % 256; end
         13, 14: e = 1;
         default: ;
      endcase
      m_acc = a;
      exp_d = a;
      exp_f = e * 4 + c * 2 + ((a == 0) ? 1 : 0);
   endfunction

   initial begin
      int ed, ef, op, ad, im, st;

      // op, addr, data, expected rsp_data, expected {err,carry,zero}
      vecs.push_back('{4'd4,  4'd0,  8'hF0, 8'hF0, 3'b000});
      vecs.push_back('{4'd0,  4'd0,  8'h20, 8'h10, 3'b010});
      vecs.push_back('{4'd4,  4'd0,  8'h05, 8'h05, 3'b000});
      vecs.push_back('{4'd1,  4'd0,  8'h05, 8'h00, 3'b001});
      vecs.push_back('{4'd1,  4'd0,  8'h01, 8'hFF, 3'b010});
      vecs.push_back('{4'd4,  4'd0,  8'h5A, 8'h5A, 3'b000});
      vecs.push_back('{4'd2,  4'd15, 8'h00, 8'h5A, 3'b000});
      vecs.push_back('{4'd4,  4'd0,  8'h00, 8'h00, 3'b001});
      vecs.push_back('{4'd3,  4'd15, 8'h00, 8'h5A, 3'b000});
      vecs.push_back('{4'd11, 4'd15, 8'h00, 8'hB4, 3'b000});
      vecs.push_back('{4'd4,  4'd0,  8'h81, 8'h81, 3'b000});
      vecs.push_back('{4'd9,  4'd0,  8'h00, 8'h02, 3'b010});
      vecs.push_back('{4'd10, 4'd0,  8'h00, 8'h01, 3'b000});
      vecs.push_back('{4'd8,  4'd0,  8'h00, 8'hFE, 3'b000});
      vecs.push_back('{4'd13, 4'd0,  8'h00, 8'hFE, 3'b100});
      vecs.push_back('{4'd14, 4'd0,  8'h00, 8'hFE, 3'b100});
      vecs.push_back('{4'd15, 4'd0,  8'h00, 8'hFE, 3'b000});
      vecs.push_back('{4'd4,  4'd0,  8'h10, 8'h10, 3'b000});
      vecs.push_back('{4'd12, 4'd15, 8'h00, 8'hB6, 3'b010});
      vecs.push_back('{4'd4,  4'd0,  8'h3C, 8'h3C, 3'b000});
      vecs.push_back('{4'd5,  4'd0,  8'h0F, 8'h0C, 3'b000});
      vecs.push_back('{4'd6,  4'd0,  8'hC0, 8'hCC, 3'b000});
      vecs.push_back('{4'd7,  4'd0,  8'hCC, 8'h00, 3'b001});
      vecs.push_back('{4'd2,  4'd3,  8'h00, 8'h00, 3'b001});
      vecs.push_back('{4'd4,  4'd0,  8'hFF, 8'hFF, 3'b000});
      vecs.push_back('{4'd0,  4'd0,  8'h01, 8'h00, 3'b011});
      vecs.push_back('{4'd11, 4'd15, 8'h00, 8'h5A, 3'b000});

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_op    = 4'd0;
      cmd_addr  = 4'd0;
      cmd_data  = 8'd0;
      rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 8'h00);
      check("rst_rsp_flags", rsp_flags, 3'b000);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 1);

      foreach (vecs[i]) begin
         do_cmd(vecs[i].op, vecs[i].addr, vecs[i].data, 0, vecs[i].exp_d, vecs[i].exp_f,
                $sformatf("vec%0d", i));
      end

      // Only address 15 was written with a non-zero value
      for (int a = 0; a < 15; a++) begin
         do_cmd(4'd3, 4'(a), 8'h00, 0, 8'h00, 3'b001, $sformatf("load_other%0d", a));
      end
      do_cmd(4'd3, 4'd15, 8'h00, 0, 8'h5A, 3'b000, "load15_again");

      // Consumer back-pressure; the LDI 0x33 offered during the stall must be ignored
      do_cmd(4'd4, 4'd0, 8'h77, 5, 8'h77, 3'b000, "stall_ldi");
      do_cmd(4'd15, 4'd0, 8'h00, 0, 8'h77, 3'b000, "stall_after_nop");

      // Reset while an ADD is in EXEC
      do_cmd(4'd4, 4'd0, 8'h40, 0, 8'h40, 3'b000, "pre_rst_ldi");
      cmd_valid = 1'b1;
      cmd_op    = 4'd0;
      cmd_addr  = 4'd0;
      cmd_data  = 8'h01;
      @(negedge clk);
      cmd_valid = 1'b0;
      check("rstexec_busy_before", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstexec_busy", busy, 0);
      check("rstexec_cmd_ready", cmd_ready, 1);
      check("rstexec_rsp_valid", rsp_valid, 0);
      check("rstexec_rsp_data", rsp_data, 8'h00);
      check("rstexec_rsp_flags", rsp_flags, 3'b000);
      @(negedge clk);
      check("rstexec_rsp_valid_hold", rsp_valid, 0);
      do_cmd(4'd3, 4'd15, 8'h00, 0, 8'h00, 3'b001, "rstexec_mem_cleared");
      do_cmd(4'd15, 4'd0, 8'h00, 0, 8'h00, 3'b001, "rstexec_acc_zero");

      // Random traffic against the model, starting from the post-reset state
      m_acc = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 0;
      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 15));
         ad = int'($urandom_range(0, 15));
         im = int'($urandom_range(0, 255));
         st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
         model(op, ad, im, ed, ef);
         do_cmd(4'(op), 4'(ad), 8'(im), st, 8'(ed), 3'(ef), $sformatf("rnd%0d_op%0d", i, op));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/acc_alu_core.md
ACC_ALU_CORE -- requirements
Module: acc_alu_core

Interface
REQ-001 Parameter DATA_W, default 8: accumulator, memory-word and data-path width; legal range 4..32.
REQ-002 Parameter MEM_DEPTH, default 16: scratch-memory entries, power of two, 2..256; ADDR_W = clog2(MEM_DEPTH).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  core can accept a command.
REQ-007 cmd_op  input  4  opcode.
REQ-008 cmd_addr  input  ADDR_W  memory address operand.
REQ-009 cmd_data  input  DATA_W  immediate operand.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  consumer takes response.
REQ-012 rsp_data  output  DATA_W  accumulator value after the command.
REQ-013 rsp_flags  output  3  {err, carry, zero} after the command.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states IDLE, EXEC, RESP; transitions: IDLE->EXEC on cmd_valid & cmd_ready; EXEC->RESP unconditionally; RESP->IDLE on rsp_ready; otherwise hold.
REQ-016 cmd_ready = 1 only in IDLE; cmd_op/addr/data latched into command registers on acceptance; inputs ignored at all other times.
REQ-017 EXEC executes the latched command, updating accumulator, memory and flags at the end of the EXEC cycle.
REQ-018 Latency: command accepted at edge N -> rsp_valid high from edge N+2; minimum spacing between accepted commands 3 cycles.
REQ-019 rsp_valid, rsp_data, rsp_flags held stable in RESP until rsp_ready sampled high.
REQ-020 Opcodes (A = accumulator, I = cmd_data, M = mem[cmd_addr]): 0 ADD A+I; 1 SUB A-I; 2 STORE M<=A; 3 LOAD A<=M; 4 LDI A<=I; 5 AND A&I; 6 OR A|I; 7 XOR A^I; 8 NOT ~A; 9 SHL A<<1; 10 SHR A>>1 (logical); 11 ADDM A+M; 12 SUBM A-M; 15 NOP.
REQ-021 Arithmetic modulo 2^DATA_W; carry = carry-out for ADD/ADDM, borrow (A < operand, unsigned) for SUB/SUBM, A[DATA_W-1] for SHL, A[0] for SHR, 0 for all other opcodes.
REQ-022 zero = (A after command == 0), evaluated for every opcode including STORE and NOP.
REQ-023 Opcodes 13, 14: A and memory unchanged, err = 1, carry = 0; err = 0 for all other opcodes.
REQ-024 STORE writes only the addressed entry; LOAD/ADDM/SUBM read memory contents from before the EXEC edge.
REQ-025 STORE then LOAD of the same address in consecutive commands returns the stored value.
REQ-026 Only the rsp_* outputs reflect flags; flags otherwise retain their last value.

Reset
REQ-027 rst has priority over all other inputs, including mid-command in EXEC or RESP; aborted command has no effect beyond state already committed.
REQ-028 Reset values: state IDLE, A = 0, all MEM_DEPTH memory entries = 0, flags = 0, rsp_valid = 0, rsp_data = 0, busy = 0, cmd_ready = 1 in the first cycle after rst deasserts.

Verification (DATA_W=8, MEM_DEPTH=16)
REQ-029 Reset, LDI 0xF0, ADD 0x20 -> rsp_data 0x10, carry 1, zero 0; rsp_valid exactly 2 edges after each acceptance.
REQ-030 LDI 0x05, SUB 0x05 -> 0x00, zero 1, carry 0; SUB 0x01 -> 0xFF, carry 1.
REQ-031 LDI 0x5A, STORE addr 15, LDI 0x00, LOAD addr 15 -> 0x5A; ADDM addr 15 -> 0xB4; all other addresses still read 0.
REQ-032 LDI 0x81, SHL -> 0x02, carry 1; SHR -> 0x01, carry 0; NOT -> 0xFE; opcode 13 -> 0xFE, err 1.
REQ-033 rsp_ready held low 5 cycles in RESP -> rsp_valid/rsp_data stable, cmd_ready 0, new cmd_valid ignored; command accepted only after release.
REQ-034 rst asserted in EXEC of an ADD -> next cycle IDLE, A = 0, rsp_valid 0, memory cleared.
